data_sram_like_responder: RTL and testbench

- Target-side model of the data-SRAM-like bus that the memory stage consumes via data_sram_data_ok/data_sram_rdata.
- Accepts CPU requests with an addr_ok handshake, performs byte-strobed writes and word reads on an internal word array, and returns data_ok/rdata strictly in order.
- Latencies are programmable so the pipeline's stall paths can be exercised (ms_ready_go held low while mem_access waits for data_ok).
- Used as the data memory in the CPU testbench and in the FPGA top.

---
 rtl/data_sram_like_responder_pkg.sv | 29 ++
 rtl/data_sram_like_responder_resp_fifo.sv | 52 +++++
 rtl/data_sram_like_responder.sv | 98 +++++++++
 tb/tb_data_sram_like_responder.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_sram_like_responder_pkg.sv
// Shared types and helpers for the data-SRAM-like responder.
// Size encodings, pending-entry layout and byte-strobe merge.
package data_sram_like_responder_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam int PEND_WD = 33;

  typedef struct packed {
    logic        wr;
    logic [31:0] data;
  } pend_t;

  function automatic logic [31:0] strb_merge(
    input logic [31:0] old_w,
    input logic [31:0] new_w,
    input logic [3:0]  strb
  );
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/data_sram_like_responder_resp_fifo.sv
// Circular FIFO holding accepted-but-unreturned responses.
// Ports: clk/resetn, push/push_data, pop/head, full/empty/count.
module data_sram_like_responder_resp_fifo #(
  parameter  int DEPTH = 2,
  parameter  int WD    = 33,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          push,
  input  logic [WD-1:0] push_data,
  input  logic          pop,
  output logic [WD-1:0] head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WD-1:0] slots [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop)  rd_ptr <= nxt(rd_ptr);
      if (push && !pop) count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) slots[wr_ptr] <= push_data;
  end

  assign head  = slots[rd_ptr];
  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);

endmodule

// File: rtl/data_sram_like_responder.sv
// Target-side data-SRAM-like bus model with programmable latencies.
// Ports: req/wr/size/addr/wstrb/wdata in; addr_ok, data_ok, rdata out.
module data_sram_like_responder
  import data_sram_like_responder_pkg::*;
#(
  parameter int AW       = 16,
  parameter int MAX_OUT  = 2,
  parameter int ADDR_DLY = 0,
  parameter int DATA_DLY = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [31:0] data_sram_addr,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata
);

  localparam int WW = (ADDR_DLY > 0) ? $clog2(ADDR_DLY + 1) : 1;
  localparam int HW = (DATA_DLY > 0) ? $clog2(DATA_DLY + 1) : 1;
  localparam int CW = $clog2(MAX_OUT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(ADDR_DLY);
  localparam logic [HW-1:0] AGE_MAX  = HW'(DATA_DLY);

  logic [31:0]        mem [2**AW];
  logic [AW-1:0]      idx;
  logic [WW-1:0]      wait_cnt;
  logic [HW-1:0]      head_age;
  logic               hs;
  logic               pop;
  logic               full;
  logic               empty;
  logic [CW-1:0]      count;
  pend_t              push_e;
  pend_t              head_e;
  logic [PEND_WD-1:0] head_raw;
  logic               unused_ok;

  // Upper address bits drop out here, so accesses wrap.
  assign idx = data_sram_addr[AW+1:2];

  // wait_cnt saturates at ADDR_DLY, so equality means "waited long enough".
  assign data_sram_addr_ok = data_sram_req && (wait_cnt == WAIT_MAX) && !full;
  assign hs = data_sram_req && data_sram_addr_ok;

  // head_age never passes DATA_DLY: the head pops on the cycle it matches.
  assign pop = !empty && (head_age == AGE_MAX);
  assign data_sram_data_ok = pop;

  assign head_e = pend_t'(head_raw);
  assign data_sram_rdata = (pop && !head_e.wr) ? head_e.data : '0;

  always_comb begin
    push_e.wr   = data_sram_wr;
    push_e.data = data_sram_wr ? '0 : mem[idx];
  end

  data_sram_like_responder_resp_fifo #(
    .DEPTH (MAX_OUT),
    .WD    (PEND_WD)
  ) u_resp_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (hs),
    .push_data (push_e),
    .pop       (pop),
    .head      (head_raw),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wait_cnt <= '0;
      head_age <= '0;
    end else begin
      if (!data_sram_req || hs) wait_cnt <= '0;
      else if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 1'b1;
      // A pop or a push into an empty queue installs a fresh head.
      if (pop || (hs && empty)) head_age <= '0;
      else if (!empty) head_age <= head_age + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (hs && data_sram_wr)
      mem[idx] <= strb_merge(mem[idx], data_sram_wdata, data_sram_wstrb);
  end

  assign unused_ok = ^{data_sram_size, data_sram_addr, count};

endmodule

// File: tb/tb_data_sram_like_responder.sv
// Randomised + directed bench for data_sram_like_responder.
// Two instances with different latencies against one behavioural model.
module tb_data_sram_like_responder;

  localparam int AWP [2] = '{4, 5};
  localparam int MOP [2] = '{2, 4};
  localparam int ADP [2] = '{0, 2};
  localparam int DDP [2] = '{3, 0};
  localparam string NM [2] = '{"A", "B"};

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req   [2];
  logic        wr    [2];
  logic [1:0]  sz    [2];
  logic [31:0] addr  [2];
  logic [3:0]  strb  [2];
  logic [31:0] wdata [2];
  logic        aok   [2];
  logic        dok   [2];
  logic [31:0] rdata [2];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  data_sram_like_responder #(
    .AW(4), .MAX_OUT(2), .ADDR_DLY(0), .DATA_DLY(3)
  ) u_a (
    .clk               (clk),
    .resetn            (resetn),
    .data_sram_req     (req[0]),
    .data_sram_wr      (wr[0]),
    .data_sram_size    (sz[0]),
    .data_sram_addr    (addr[0]),
    .data_sram_wstrb   (strb[0]),
    .data_sram_wdata   (wdata[0]),
    .data_sram_addr_ok (aok[0]),
    .data_sram_data_ok (dok[0]),
    .data_sram_rdata   (rdata[0])
  );

  data_sram_like_responder #(
    .AW(5), .MAX_OUT(4), .ADDR_DLY(2), .DATA_DLY(0)
  ) u_b (
    .clk               (clk),
    .resetn            (resetn),
    .data_sram_req     (req[1]),
    .data_sram_wr      (wr[1]),
    .data_sram_size    (sz[1]),
    .data_sram_addr    (addr[1]),
    .data_sram_wstrb   (strb[1]),
    .data_sram_wdata   (wdata[1]),
    .data_sram_addr_ok (aok[1]),
    .data_sram_data_ok (dok[1]),
    .data_sram_rdata   (rdata[1])
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_chk++;
    n_err++;
    $display("FAIL %s: timed out waiting for DUT", nm);
  endtask

  // Behavioural model: memory image, response queue, per-head start cycle.
  logic [31:0] mmem [2][32];
  logic [31:0] mqd  [2][8];
  int mhd [2];
  int mcnt [2];
  int mwait [2];
  int mstart [2];
  int cyc = 0;

  task automatic model_step(input int k);
    logic        ea;
    logic        ed;
    logic [31:0] er;
    logic [31:0] v;
    int          idx;
    bit          popped;
    bit          was_empty;
    if (!resetn) begin
      mcnt[k]  = 0;
      mhd[k]   = 0;
      mwait[k] = 0;
      chk({NM[k], "_rst_addr_ok"}, 32'(aok[k]),
          32'(req[k] && ADP[k] == 0));
      chk({NM[k], "_rst_data_ok"}, 32'(dok[k]), 32'd0);
      chk({NM[k], "_rst_rdata"}, rdata[k], 32'd0);
      return;
    end
    ea = req[k] && (mwait[k] >= ADP[k]) && (mcnt[k] < MOP[k]);
    ed = (mcnt[k] > 0) && (cyc - mstart[k] == DDP[k]);
    er = ed ? mqd[k][mhd[k]] : 32'd0;
    chk({NM[k], "_addr_ok"}, 32'(aok[k]), 32'(ea));
    chk({NM[k], "_data_ok"}, 32'(dok[k]), 32'(ed));
    chk({NM[k], "_rdata"}, rdata[k], er);
    popped = 0;
    if (ed) begin
      mhd[k] = (mhd[k] + 1) % 8;
      mcnt[k]--;
      popped = 1;
    end
    was_empty = (mcnt[k] == 0);
    if (ea) begin
      idx = int'((addr[k] >> 2) & ((32'd1 << AWP[k]) - 1));
      if (wr[k]) begin
        for (int i = 0; i < 4; i++)
          if (strb[k][i]) mmem[k][idx][8*i +: 8] = wdata[k][8*i +: 8];
        v = 32'd0;
      end else begin
        v = mmem[k][idx];
      end
      mqd[k][(mhd[k] + mcnt[k]) % 8] = v;
      mcnt[k]++;
    end
    if (mcnt[k] > 0 && (popped || was_empty)) mstart[k] = cyc + 1;
    if (req[k] && !ea) mwait[k]++;
    else mwait[k] = 0;
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) model_step(k);
    cyc++;
  end

  task automatic issue(input int k, input logic w, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] d);
    int n;
    n = 0;
    wr[k] = w; addr[k] = a; strb[k] = s; wdata[k] = d;
    sz[k] = 2'd2; req[k] = 1'b1;
    forever begin
      @(negedge clk);
      if (aok[k]) break;
      n++;
      if (n > 40) begin
        timeout({NM[k], "_issue"});
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    req[k] = 1'b0;
  endtask

  task automatic await_resp(input int k, input logic [31:0] exp,
                            input string nm);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (dok[k]) break;
      n++;
      if (n > 40) begin
        timeout(nm);
        @(posedge clk); #1;
        return;
      end
    end
    chk(nm, rdata[k], exp);
    @(posedge clk); #1;
  endtask

  task automatic xact(input int k, input logic w, input logic [31:0] a,
                      input logic [3:0] s, input logic [31:0] d,
                      input logic [31:0] exp, input string nm);
    issue(k, w, a, s, d);
    await_resp(k, exp, nm);
  endtask

  task automatic run_vec(input int k, input int n, input logic [15:0] mask,
                         output logic [15:0] av, output logic [15:0] dv);
    av = '0;
    dv = '0;
    wr[k] = 1'b0;
    for (int i = 0; i < n; i++) begin
      req[k] = mask[i];
      @(negedge clk);
      av[i] = aok[k];
      dv[i] = dok[k];
      @(posedge clk); #1;
    end
    req[k] = 1'b0;
  endtask

  task automatic rand_run(input int k);
    logic hold;
    hold = 1'b0;
    for (int c = 0; c < 800; c++) begin
      if (!(hold && $urandom_range(0, 9) < 9)) begin
        req[k]   = ($urandom_range(0, 9) < 6);
        wr[k]    = 1'($urandom_range(0, 1));
        addr[k]  = $urandom;
        strb[k]  = 4'($urandom);
        wdata[k] = $urandom;
        sz[k]    = 2'($urandom_range(0, 2));
      end
      @(negedge clk);
      hold = req[k] && !aok[k];
      @(posedge clk); #1;
    end
    req[k] = 1'b0;
  endtask

  initial begin
    logic [15:0] av;
    logic [15:0] dv;
    bit          seen;
    for (int k = 0; k < 2; k++) begin
      req[k] = 0; wr[k] = 0; sz[k] = 0; addr[k] = 0;
      strb[k] = 0; wdata[k] = 0;
      mhd[k] = 0; mcnt[k] = 0; mwait[k] = 0; mstart[k] = 0;
    end
    resetn = 1'b0;
    @(negedge clk);
    chk("reset_data_ok_A", 32'(dok[0]), 32'd0);
    chk("reset_rdata_B", rdata[1], 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;

    for (int k = 0; k < 2; k++)
      for (int i = 0; i < (1 << AWP[k]); i++)
        xact(k, 1'b1, 32'(i * 4), 4'hF, $urandom, 32'd0, "fill_wr");

    xact(0, 1'b1, 32'h100, 4'hF, 32'h11223344, 32'd0, "word_wr_resp");
    xact(0, 1'b0, 32'h100, 4'h0, 32'd0, 32'h11223344, "word_rd");
    xact(0, 1'b1, 32'h40, 4'hF, 32'hCAFEF00D, 32'd0, "wrap_wr_resp");
    xact(0, 1'b0, 32'h0, 4'h0, 32'd0, 32'hCAFEF00D, "wrap_rd");

    xact(0, 1'b1, 32'h44, 4'hF, 32'hAABBCCDD, 32'd0, "strb_init");
    xact(0, 1'b1, 32'h44, 4'b0010, 32'h0000EE00, 32'd0, "strb_b1");
    xact(0, 1'b1, 32'h44, 4'b1100, 32'h12340000, 32'd0, "strb_h1");
    xact(0, 1'b0, 32'h44, 4'h0, 32'd0, 32'h1234EEDD, "strb_rd");

    addr[0] = 32'h44;
    run_vec(0, 13, 16'h003F, av, dv);
    chk("bp_addr_ok_seq", 32'(av), 32'h0023);
    chk("bp_data_ok_seq", 32'(dv), 32'h1110);

    run_vec(0, 2, 16'h0003, av, dv);
    chk("pre_rst_accepts", 32'(av), 32'h0003);
    resetn = 1'b0;
    @(negedge clk);
    chk("mid_rst_data_ok", 32'(dok[0]), 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      seen = seen | dok[0];
      @(posedge clk); #1;
    end
    chk("post_rst_no_data_ok", 32'(seen), 32'd0);
    xact(0, 1'b0, 32'h44, 4'h0, 32'd0, 32'h1234EEDD, "post_rst_rd");
    run_vec(0, 2, 16'h0003, av, dv);
    chk("post_rst_empty_q", 32'(av), 32'h0003);
    repeat (12) @(posedge clk);
    #1;

    addr[1] = 32'h8;
    run_vec(1, 12, 16'h01D7, av, dv);
    chk("adly_addr_ok_seq", 32'(av), 32'h0104);
    chk("ddly0_data_ok_seq", 32'(dv), 32'h0208);

    fork
      rand_run(0);
      rand_run(1);
    join

    repeat (30) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
